// File: rtl/imem_dmem_arbiter.sv
// imem_dmem_arbiter: shares one single-port variable-latency memory between fetch and data ports
module imem_dmem_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            stall_if,
  output logic            stall_mem,
  output logic            bus_err
);
  localparam int SW = $clog2(STARVE_MAX + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [2:0] IDLE = 3'd0, BUSY_I = 3'd1, BUSY_D = 3'd2, RESP_I = 3'd3, RESP_D = 3'd4;
  logic [2:0] state;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic grant_d, tmo_hit;
  assign grant_d = d_req & (~if_req | (starve_cnt < SW'(STARVE_MAX)));
  assign tmo_hit = tmo_cnt == TW'(TIMEOUT - 1);
  assign stall_if = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      starve_cnt <= '0;
      tmo_cnt <= '0;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_be <= '0;
      if_rdata <= '0;
      d_rdata <= '0;
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      bus_err <= 1'b0;
    end else begin
      if_ack <= 1'b0;
      d_ack <= 1'b0;
      bus_err <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_d) begin
            mem_req <= 1'b1;
            mem_we <= d_we;
            mem_addr <= d_addr;
            mem_wdata <= d_wdata;
            mem_be <= d_be;
            tmo_cnt <= '0;
            starve_cnt <= if_req ? starve_cnt + 1'b1 : '0;
            state <= BUSY_D;
          end else if (if_req) begin
            mem_req <= 1'b1;
            mem_we <= 1'b0;
            mem_addr <= if_addr;
            mem_wdata <= '0;
            mem_be <= '1;
            tmo_cnt <= '0;
            starve_cnt <= '0;
            state <= BUSY_I;
          end
        end
        BUSY_I, BUSY_D: begin
          tmo_cnt <= tmo_cnt + 1'b1;
          // a real ack wins over a timeout landing in the same cycle
          if (mem_ack | tmo_hit) begin
            mem_req <= 1'b0;
            bus_err <= ~mem_ack;
            if (state == BUSY_I) begin
              if_ack <= 1'b1;
              if_rdata <= mem_ack ? mem_rdata : '0;
              state <= RESP_I;
            end else begin
              d_ack <= 1'b1;
              if (~mem_ack | ~mem_we) d_rdata <= mem_ack ? mem_rdata : '0;
              state <= RESP_D;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// tb_imem_dmem_arbiter: directed scenarios plus randomized traffic against a transaction-level model
module tb_imem_dmem_arbiter;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, d_req = 0, d_we = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, d_addr = 0, d_wdata = 0, mem_rdata = 0;
  logic [3:0] d_be = 0;
  logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0] mem_be;
  logic if_ack, d_ack, mem_req, mem_we, stall_if, stall_mem, bus_err;
  int total = 0, bad = 0;
  int wait_cycles = 0, cnt = 0;
  bit silent = 0, spur = 0;
  logic [31:0] mem_words [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];

  imem_dmem_arbiter #(.AW(32), .DW(32), .STARVE_MAX(4), .TIMEOUT(8)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be), .d_rdata(d_rdata),
    .d_ack(d_ack), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack), .stall_if(stall_if),
    .stall_mem(stall_mem), .bus_err(bus_err));

  always #5 clk = ~clk;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h100) ? 32'h00500093 : (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] w, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = w[8*i +: 8];
    return r;
  endfunction

  // memory: acks after wait_cycles extra cycles of mem_req, or never when silent
  always @(negedge clk) begin
    if (mem_req) begin
      cnt = cnt + 1;
      mem_ack = !silent && cnt == wait_cycles + 1;
      if (mem_ack) begin
        mem_rdata = mem_words.exists(mem_addr) ? mem_words[mem_addr] : dflt(mem_addr);
        if (mem_we) mem_words[mem_addr] = merge(mem_rdata, mem_wdata, mem_be);
      end
    end else begin
      cnt = 0;
      mem_ack = spur;
      if (spur) mem_rdata = $urandom;
    end
  end

  task automatic do_reset;
    rst_n = 0; if_req = 0; d_req = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    silent = 0; spur = 0; wait_cycles = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_reset;
    do_reset;
    total++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_rdata, if_ack, d_rdata, d_ack, bus_err, stall_if, stall_mem} !== '0) begin
      bad++; $display("FAIL reset_outputs: got req=%b ack=%b/%b addr=%h rd=%h/%h", mem_req, if_ack, d_ack, mem_addr, if_rdata, d_rdata);
    end
  endtask

  task automatic test_fetch;
    do_reset;
    if_req = 1; if_addr = 32'h100;
    #1 total++;
    if ({stall_if, mem_req} !== 2'b10) begin bad++; $display("FAIL fetch_c0: got stall_if,mem_req=%b want 10", {stall_if, mem_req}); end
    @(negedge clk); total++;
    if ({mem_req, mem_we, mem_be, mem_addr, stall_if, if_ack} !== {1'b1, 1'b0, 4'hF, 32'h100, 1'b1, 1'b0}) begin
      bad++; $display("FAIL fetch_c1: got req=%b we=%b be=%h addr=%h stall=%b ack=%b", mem_req, mem_we, mem_be, mem_addr, stall_if, if_ack);
    end
    @(negedge clk); total++;
    if ({if_ack, d_ack, stall_if, if_rdata} !== {1'b1, 1'b0, 1'b0, 32'h00500093}) begin
      bad++; $display("FAIL fetch_c2: got ack=%b d_ack=%b stall=%b rdata=%h want 1 0 0 00500093", if_ack, d_ack, stall_if, if_rdata);
    end
    if_req = 0;
    @(negedge clk); total++;
    if ({if_ack, mem_req} !== 2'b00) begin bad++; $display("FAIL fetch_c3: got ack,req=%b want 00", {if_ack, mem_req}); end
  endtask

  task automatic test_store;
    do_reset;
    wait_cycles = 3;
    d_req = 1; d_we = 1; d_addr = 32'h2000; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk); total++;
      if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, d_ack, if_ack, stall_mem} !== {1'b1, 1'b1, 32'h2000, 32'hDEADBEEF, 4'b0011, 1'b0, 1'b0, 1'b1}) begin
        bad++; $display("FAIL store_hold c%0d: got req=%b we=%b addr=%h wd=%h be=%h ack=%b/%b", k, mem_req, mem_we, mem_addr, mem_wdata, mem_be, d_ack, if_ack);
      end
    end
    @(negedge clk); total++;
    if ({d_ack, if_ack, mem_req, bus_err, d_rdata} !== {1'b1, 1'b0, 1'b0, 1'b0, 32'h0}) begin
      bad++; $display("FAIL store_ack: got d_ack=%b if_ack=%b req=%b err=%b rdata=%h", d_ack, if_ack, mem_req, bus_err, d_rdata);
    end
    d_req = 0; d_we = 0;
    @(negedge clk); total++;
    if (d_ack !== 1'b0) begin bad++; $display("FAIL store_ack_pulse: got d_ack=%b want 0", d_ack); end
    wait_cycles = 0;
  endtask

  task automatic test_starve;
    int starve = 0;
    bit exp_d, got;
    do_reset;
    if_req = 1; if_addr = 32'h40; d_req = 1; d_we = 0; d_addr = 32'h80;
    for (int n = 0; n < 10; n++) begin
      exp_d = starve < 4;
      starve = exp_d ? starve + 1 : 0;
      got = 0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk); total++;
        if (if_ack & d_ack) begin bad++; $display("FAIL starve_both_acks: got if_ack=1 d_ack=1 want at most one"); end
        if (if_ack | d_ack) begin
          got = 1; total++;
          if (d_ack !== exp_d) begin bad++; $display("FAIL starve_order grant %0d: got d_ack=%b want %b", n, d_ack, exp_d); end
        end
      end
      if (!got) begin total++; bad++; $display("FAIL starve_wait grant %0d: got no ack want ack within 10 cycles", n); end
    end
    if_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  task automatic test_timeout;
    int hi = 0;
    bit got = 0;
    do_reset;
    d_req = 1; d_we = 0; d_addr = 32'h300;
    for (int c = 0; c < 10 && !got; c++) begin @(negedge clk); got = d_ack; end
    total++;
    if (!got || d_rdata !== dflt(32'h300)) begin bad++; $display("FAIL tmo_preload: got ack=%b rdata=%h want %h", got, d_rdata, dflt(32'h300)); end
    d_req = 0;
    @(negedge clk);
    silent = 1; d_req = 1; d_addr = 32'h304;
    got = 0;
    for (int c = 0; c < 40 && !got; c++) begin
      @(negedge clk);
      if (mem_req) hi++;
      got = d_ack;
    end
    total++;
    if (hi !== 8) begin bad++; $display("FAIL tmo_req_cycles: got %0d want 8", hi); end
    total++;
    if ({d_ack, bus_err, if_ack, d_rdata} !== {1'b1, 1'b1, 1'b0, 32'h0}) begin
      bad++; $display("FAIL tmo_abort: got d_ack=%b bus_err=%b if_ack=%b rdata=%h want 1 1 0 0", d_ack, bus_err, if_ack, d_rdata);
    end
    d_req = 0; silent = 0;
    @(negedge clk); total++;
    if ({bus_err, d_ack} !== 2'b00) begin bad++; $display("FAIL tmo_pulse: got err,ack=%b want 00", {bus_err, d_ack}); end
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    @(negedge clk); total++;
    if ({if_ack, bus_err, if_rdata} !== {1'b1, 1'b0, 32'h00500093}) begin
      bad++; $display("FAIL tmo_next: got ack=%b err=%b rdata=%h want 1 0 00500093", if_ack, bus_err, if_rdata);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_reset_busy;
    do_reset;
    silent = 1; d_req = 1; d_we = 0; d_addr = 32'h308;
    repeat (3) @(negedge clk);
    total++;
    if (mem_req !== 1'b1) begin bad++; $display("FAIL rb_busy: got mem_req=%b want 1", mem_req); end
    rst_n = 0;
    #1 total++;
    if ({mem_req, d_ack} !== 2'b00) begin bad++; $display("FAIL rb_drop: got req,ack=%b want 00", {mem_req, d_ack}); end
    silent = 0; d_req = 0;
    @(negedge clk);
    rst_n = 1; if_req = 1; if_addr = 32'h100;
    @(negedge clk); total++;
    if ({mem_req, mem_addr, d_ack} !== {1'b1, 32'h100, 1'b0}) begin
      bad++; $display("FAIL rb_regrant: got req=%b addr=%h d_ack=%b", mem_req, mem_addr, d_ack);
    end
    @(negedge clk); total++;
    if ({if_ack, d_ack, if_rdata} !== {1'b1, 1'b0, 32'h00500093}) begin
      bad++; $display("FAIL rb_fetch: got ack=%b d_ack=%b rdata=%h", if_ack, d_ack, if_rdata);
    end
    if_req = 0;
    @(negedge clk);
  endtask

  task automatic test_spurious;
    do_reset;
    if_req = 1; if_addr = 32'h100;
    repeat (2) @(negedge clk);
    if_req = 0;
    @(negedge clk);
    spur = 1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); total++;
      if ({if_ack, d_ack, mem_req, bus_err, if_rdata, d_rdata} !== {4'b0, 32'h00500093, 32'h0}) begin
        bad++; $display("FAIL spur_idle c%0d: got ack=%b/%b req=%b rd=%h/%h", k, if_ack, d_ack, mem_req, if_rdata, d_rdata);
      end
    end
    spur = 0;
    @(negedge clk);
    if_req = 1; if_addr = 32'h100;
    @(negedge clk);
    spur = 1;
    @(negedge clk);
    if_req = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); total++;
      if ({if_ack, d_ack, mem_req, bus_err, if_rdata} !== {4'b0, 32'h00500093}) begin
        bad++; $display("FAIL spur_resp c%0d: got ack=%b/%b req=%b rd=%h", k, if_ack, d_ack, mem_req, if_rdata);
      end
    end
    spur = 0;
    @(negedge clk);
  endtask

  function automatic logic [31:0] rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : dflt(a);
  endfunction

  task automatic new_i;
    if_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endtask

  task automatic new_d;
    d_we = 1'($urandom); d_addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
    d_wdata = $urandom; d_be = 4'($urandom_range(1, 15));
  endtask

  task automatic test_random;
    int starve = 0;
    bit g_d, saw, got;
    logic [31:0] exp_drd = 0, exp;
    logic [68:0] ebus;
    do_reset;
    if_req = 1'($urandom); d_req = ~if_req | 1'($urandom);
    new_i; new_d;
    for (int r = 0; r < 60; r++) begin
      wait_cycles = $urandom_range(0, 3);
      g_d = d_req && (!if_req || starve < 4);
      starve = g_d ? (if_req ? starve + 1 : 0) : 0;
      ebus = g_d ? {d_we, d_addr, d_wdata, d_be} : {1'b0, if_addr, 32'h0, 4'hF};
      saw = 0; got = 0;
      for (int c = 0; c < 30 && !got; c++) begin
        @(negedge clk);
        if (mem_req && !saw) begin
          saw = 1; total++;
          if ({mem_we, mem_addr, mem_wdata, mem_be} !== ebus) begin
            bad++; $display("FAIL rnd_bus r%0d: got %h want %h", r, {mem_we, mem_addr, mem_wdata, mem_be}, ebus);
          end
        end
        if (if_ack | d_ack) begin
          got = 1; total++;
          if ({if_ack, d_ack, bus_err} !== {!g_d, g_d, 1'b0}) begin
            bad++; $display("FAIL rnd_grant r%0d: got if_ack,d_ack,err=%b want %b", r, {if_ack, d_ack, bus_err}, {!g_d, g_d, 1'b0});
          end
          total++;
          if (!g_d) begin
            exp = rd(if_addr);
            if (if_rdata !== exp) begin bad++; $display("FAIL rnd_fetch r%0d: got %h want %h", r, if_rdata, exp); end
            if_req = 1'($urandom); new_i;
          end else begin
            if (d_we) shadow[d_addr] = merge(rd(d_addr), d_wdata, d_be);
            else exp_drd = rd(d_addr);
            if (d_rdata !== exp_drd) begin bad++; $display("FAIL rnd_data r%0d we=%b: got %h want %h", r, d_we, d_rdata, exp_drd); end
            d_req = 1'($urandom); new_d;
          end
          if (!if_req && !d_req) if_req = 1;
        end
      end
      if (!got) begin
        total++; bad++; $display("FAIL rnd_wait r%0d: got no ack want ack within 30 cycles", r);
        if_req = 0; d_req = 0;
        return;
      end
    end
    if_req = 0; d_req = 0;
    @(negedge clk);
  endtask

  initial begin
    test_reset;
    test_fetch;
    test_store;
    test_starve;
    test_timeout;
    test_reset_busy;
    test_spurious;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
